pipeline_hazard_control: RTL

PIPELINE_HAZARD_CONTROL -- requirements
Module: pipeline_hazard_control

---
 rtl/pipeline_hazard_control_if.sv | 47 ++++
 rtl/pipeline_hazard_control.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_control_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pipeline_hazard_control_if
// Description : Signal bundle between the pipeline datapath and the hazard
//               controller.
//               master : pipeline side (drives instruction/status, receives
//                        stall/bubble/flush controls and counters)
//               slave  : hazard controller side
// Ports       : decode_valid/decode_instr, execute_valid/execute_instr,
//               mem_busy, branch_taken            (master -> slave)
//               stall_fetch, stall_decode, stall_execute, bubble_execute,
//               flush, ctrl_state, stall_cycles, flush_events
//                                                  (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_control_if;
    logic        decode_valid;
    logic [15:0] decode_instr;
    logic        execute_valid;
    logic [15:0] execute_instr;
    logic        mem_busy;
    logic        branch_taken;
    logic        stall_fetch;
    logic        stall_decode;
    logic        stall_execute;
    logic        bubble_execute;
    logic        flush;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    modport master (
        output decode_valid, decode_instr, execute_valid, execute_instr,
               mem_busy, branch_taken,
        input  stall_fetch, stall_decode, stall_execute, bubble_execute,
               flush, ctrl_state, stall_cycles, flush_events
    );

    modport slave (
        input  decode_valid, decode_instr, execute_valid, execute_instr,
               mem_busy, branch_taken,
        output stall_fetch, stall_decode, stall_execute, bubble_execute,
               flush, ctrl_state, stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pipeline_hazard_control
// Description : Stall / bubble / flush controller for a short in-order
//               pipeline. Detects load-use hazards between execute and
//               decode, holds the pipe while memory is busy and flushes the
//               front end for two cycles after a taken branch.
// Ports       : clk   - rising-edge clock
//               reset - synchronous, active-high reset
//               hif   - pipeline_hazard_control_if.slave (instruction and
//                       status inputs; stall/bubble/flush, state and
//                       performance-counter outputs)
// Config      : define HAZARD_PERF_CNT_EN to build the saturating
//               stall_cycles / flush_events counters; otherwise both read 0.
// Revision    : 1.0 - initial release
// ============================================================================

// Instruction class encodings in instr[15:14] (overridable at build time).
`ifndef R_TYPE
`define R_TYPE 2'b00
`endif
`ifndef A_TYPE
`define A_TYPE 2'b01
`endif

module pipeline_hazard_control (
    input  wire logic                    clk,
    input  wire logic                    reset,
    pipeline_hazard_control_if.slave     hif
);

    localparam logic [3:0] c_LOAD_OPC = 4'b1000;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_pend_branch;
    logic       w_pend_next;
    logic [1:0] r_flush_cnt;
    logic [1:0] w_flush_cnt_next;

    logic       w_stall_fd;
    logic       w_stall_ex;
    logic       w_bubble;
    logic       w_flush;

    // ------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------
    logic       w_exec_is_load;
    logic       w_dec_is_reader;
    logic [2:0] w_load_dst;
    logic [2:0] w_dec_rm;
    logic [2:0] w_dec_rn;
    logic       w_load_use;

    assign w_exec_is_load  = (hif.execute_instr[15:12] == c_LOAD_OPC);
    assign w_dec_is_reader = (hif.decode_instr[15:14] == `A_TYPE) ||
                             (hif.decode_instr[15:14] == `R_TYPE);
    assign w_load_dst      = hif.execute_instr[2:0];
    assign w_dec_rm        = hif.decode_instr[8:6];
    assign w_dec_rn        = hif.decode_instr[5:3];

    assign w_load_use = hif.execute_valid && w_exec_is_load &&
                        hif.decode_valid  && w_dec_is_reader &&
                        ((w_load_dst == w_dec_rm) || (w_load_dst == w_dec_rn));

    // Instruction fields that play no part in hazard detection.
    logic w_unused;
    assign w_unused = &{1'b0, hif.decode_instr[13:9], hif.decode_instr[2:0],
                        hif.execute_instr[11:3]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pend_branch <= 1'b0;
            r_flush_cnt   <= 2'd0;
        end else begin
            r_state       <= w_next_state;
            r_pend_branch <= w_pend_next;
            r_flush_cnt   <= w_flush_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state     = r_state;
        w_pend_next      = r_pend_branch;
        w_flush_cnt_next = r_flush_cnt;
        w_stall_fd       = 1'b0;
        w_stall_ex       = 1'b0;
        w_bubble         = 1'b0;
        w_flush          = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (hif.branch_taken) begin
                    // Redirect wins over everything: flush this cycle and
                    // one more cycle in FLUSH.
                    w_flush          = 1'b1;
                    w_flush_cnt_next = 2'd1;
                    w_next_state     = ST_FLUSH;
                end else if (hif.mem_busy) begin
                    w_stall_fd   = 1'b1;
                    w_stall_ex   = 1'b1;
                    w_next_state = ST_MEM_WAIT;
                end else if (w_load_use) begin
                    // Hold the front end one cycle and send a NOP into
                    // execute; the load moves on, so execute is not held.
                    w_stall_fd = 1'b1;
                    w_bubble   = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                w_stall_fd = hif.mem_busy;
                w_stall_ex = hif.mem_busy;
                if (hif.mem_busy) begin
                    // The redirect cannot act while the pipe is frozen;
                    // remember it until memory releases.
                    if (hif.branch_taken) begin
                        w_pend_next = 1'b1;
                    end
                end else if (r_pend_branch || hif.branch_taken) begin
                    w_flush          = 1'b1;
                    w_flush_cnt_next = 2'd1;
                    w_pend_next      = 1'b0;
                    w_next_state     = ST_FLUSH;
                end else begin
                    w_next_state = ST_RUN;
                end
            end

            ST_FLUSH: begin
                w_flush    = 1'b1;
                w_stall_fd = hif.mem_busy;
                w_stall_ex = hif.mem_busy;
                if (hif.branch_taken) begin
                    // A fresh redirect restarts the flush window.
                    w_flush_cnt_next = 2'd1;
                end else if (r_flush_cnt > 2'd1) begin
                    w_flush_cnt_next = r_flush_cnt - 2'd1;
                end else begin
                    w_flush_cnt_next = 2'd0;
                    w_next_state     = hif.mem_busy ? ST_MEM_WAIT : ST_RUN;
                end
            end

            default: begin
                // Unreachable encoding: recover to RUN, drive nothing.
                w_pend_next      = 1'b0;
                w_flush_cnt_next = 2'd0;
                w_next_state     = ST_RUN;
            end
        endcase
    end

    // Controls are forced low while reset is held.
    assign hif.stall_fetch    = w_stall_fd & ~reset;
    assign hif.stall_decode   = w_stall_fd & ~reset;
    assign hif.stall_execute  = w_stall_ex & ~reset;
    assign hif.bubble_execute = w_bubble & ~w_flush & ~reset;
    assign hif.flush          = w_flush & ~reset;
    assign hif.ctrl_state     = r_state;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_events;
    logic        r_flush_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 16'h0000;
            r_flush_events <= 16'h0000;
            r_flush_prev   <= 1'b0;
        end else begin
            r_flush_prev <= hif.flush;
            if (hif.stall_fetch && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            // Count flush bursts, not flush cycles.
            if (hif.flush && !r_flush_prev && (r_flush_events != 16'hFFFF)) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
        end
    end

    assign hif.stall_cycles = r_stall_cycles;
    assign hif.flush_events = r_flush_events;
`else
    assign hif.stall_cycles = 16'h0000;
    assign hif.flush_events = 16'h0000;
`endif

endmodule
`default_nettype wire
